// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the sequence-detector path:
// serializer FSM states, idle level and detector state encodings.
package seq_bit_serializer_pkg;

    typedef enum logic {
        SER_EMPTY = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam logic DEFAULT_IDLE_BIT = 1'b0;

    // Detector encodings live here so detector and serializer agree.
    typedef enum logic [2:0] {
        DET_IDLE = 3'd0,
        DET_S1   = 3'd1,
        DET_S10  = 3'd2,
        DET_S101 = 3'd3,
        DET_SEEN = 3'd4
    } det_state_e;

endpackage

// File: rtl/seq_word_hold_reg.sv
// One-entry valid-tagged word register with load and take controls.
// Load wins over take; the serializer never asserts both together.
module seq_word_hold_reg
    import seq_bit_serializer_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              take,
    output logic              full,
    output logic [WORD_W-1:0] data
);

    logic              full_q;
    logic              full_d;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (take) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector.
// A holding register lets back-to-back words stream without a gap.
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int CW = $clog2(WORD_W);

    ser_state_e        state_q;
    ser_state_e        state_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    logic              hold_full;
    logic [WORD_W-1:0] hold_data;
    logic              hold_load;
    logic              hold_take;
    logic              accept;
    logic              last_bit;
    logic              head_bit;
    logic [WORD_W-1:0] shifted;

    assign accept   = in_valid && !hold_full;
    assign last_bit = (state_q == SER_SHIFT) && (cnt_q == CW'(WORD_W - 1));
    assign head_bit = MSB_FIRST ? shift_q[WORD_W-1] : shift_q[0];
    assign shifted  = MSB_FIRST ? {shift_q[WORD_W-2:0], IDLE_BIT}
                                : {IDLE_BIT, shift_q[WORD_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SER_EMPTY;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_EMPTY: if (accept) state_d = SER_SHIFT;
            SER_SHIFT: if (last_bit && !hold_full && !accept) state_d = SER_EMPTY;
        endcase
    end

    // On the last bit the next word comes from hold first, else straight from the input.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        hold_load = 1'b0;
        hold_take = 1'b0;
        unique case (state_q)
            SER_EMPTY: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                end
            end
            SER_SHIFT: begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        shift_d   = hold_data;
                        hold_take = 1'b1;
                    end else if (accept) begin
                        shift_d = in_data;
                    end
                end else if (accept) begin
                    hold_load = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == SER_SHIFT);
        out_bit   = out_valid ? head_bit : IDLE_BIT;
        out_last  = last_bit;
        in_ready  = !hold_full;
        busy      = out_valid || hold_full;
    end

    seq_word_hold_reg #(
        .WORD_W(WORD_W)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_data(in_data),
        .take     (hold_take),
        .full     (hold_full),
        .data     (hold_data)
    );

endmodule
